// File: rtl/ray_move_gen.sv
// ray_move_gen: time-multiplexed pseudo-legal move generator for knight, bishop, rook, queen and king.
// Scans a latched board snapshot and emits one move per valid/ready handshake.
module ray_move_gen #(
    parameter int         BOARD_W    = 8,
    parameter int         BOARD_H    = 8,
    parameter logic [7:0] PIECE_MASK = 8'b0111_1100,
    parameter int         CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         side,
    input  logic                         caps_only,
    input  logic [BOARD_W*BOARD_H*4-1:0] board,
    output logic                         mv_valid,
    input  logic                         mv_ready,
    output logic [2:0]                   mv_from_x,
    output logic [2:0]                   mv_from_y,
    output logic [2:0]                   mv_to_x,
    output logic [2:0]                   mv_to_y,
    output logic [2:0]                   mv_cap,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             move_count
);
    typedef enum logic [2:0] {IDLE, SCAN, DIR, STEP, EMIT, FIN} state_t;
    localparam int N = BOARD_W * BOARD_H;
    localparam logic signed [4:0] W5 = 5'(BOARD_W);
    localparam logic signed [4:0] H5 = 5'(BOARD_H);
    localparam logic signed [4:0] RX [8] = '{5'sd0, 5'sd1, 5'sd1, 5'sd1, 5'sd0, -5'sd1, -5'sd1, -5'sd1};
    localparam logic signed [4:0] RY [8] = '{5'sd1, 5'sd1, 5'sd0, -5'sd1, -5'sd1, -5'sd1, 5'sd0, 5'sd1};
    localparam logic signed [4:0] KX [8] = '{5'sd1, 5'sd2, 5'sd2, 5'sd1, -5'sd1, -5'sd2, -5'sd2, -5'sd1};
    localparam logic signed [4:0] KY [8] = '{5'sd2, 5'sd1, -5'sd1, -5'sd2, -5'sd2, -5'sd1, 5'sd1, 5'sd2};

    state_t            state;
    logic [3:0]        cells [64];
    logic [255:0]      board_pad;
    logic              side_r, caps_r, cont;
    logic [6:0]        s;
    logic [2:0]        sx, sy, ox, oy, tx, ty, ptype, cd;
    logic [3:0]        dn;
    logic [3:0]        sq, tq;
    logic              sel, knight, slider, t_empty, own, on_brd, wrap;
    logic signed [4:0] nx, ny;
    logic [5:0]        ti;

    // Squares beyond the configured board are padded as empty so all lookups use a 64-entry table.
    assign board_pad = 256'(board);

    always_comb begin
        sq      = cells[s[5:0]];
        sel     = sq[3] == side_r && sq[2:0] >= 3'd2 && sq[2:0] <= 3'd6 && PIECE_MASK[sq[2:0]];
        knight  = ptype == 3'd2;
        slider  = ptype == 3'd3 || ptype == 3'd4 || ptype == 3'd5;
        nx      = $signed({2'b00, tx}) + (knight ? KX[cd] : RX[cd]);
        ny      = $signed({2'b00, ty}) + (knight ? KY[cd] : RY[cd]);
        on_brd  = !nx[4] && !ny[4] && nx < W5 && ny < H5;
        ti      = 6'(ny[2:0]) * 6'(BOARD_W) + 6'(nx[2:0]);
        tq      = cells[ti];
        t_empty = tq[2:0] == 3'd0 || tq[2:0] == 3'd7;
        own     = !t_empty && tq[3] == side_r;
        wrap    = sx == 3'(BOARD_W - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mv_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            move_count <= '0;
            mv_from_x  <= 3'd0;
            mv_from_y  <= 3'd0;
            mv_to_x    <= 3'd0;
            mv_to_y    <= 3'd0;
            mv_cap     <= 3'd0;
            side_r     <= 1'b0;
            caps_r     <= 1'b0;
            cont       <= 1'b0;
            s          <= 7'd0;
            sx         <= 3'd0;
            sy         <= 3'd0;
            ox         <= 3'd0;
            oy         <= 3'd0;
            tx         <= 3'd0;
            ty         <= 3'd0;
            ptype      <= 3'd0;
            cd         <= 3'd0;
            dn         <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < 64; i++) cells[i] <= board_pad[4*i +: 4];
                    side_r     <= side;
                    caps_r     <= caps_only;
                    move_count <= '0;
                    s          <= 7'd0;
                    sx         <= 3'd0;
                    sy         <= 3'd0;
                    busy       <= 1'b1;
                    state      <= SCAN;
                end
                SCAN: if (s == 7'(N)) begin
                    state <= FIN;
                end else if (sel) begin
                    ox    <= sx;
                    oy    <= sy;
                    ptype <= sq[2:0];
                    dn    <= sq[2:0] == 3'd3 ? 4'd1 : 4'd0;
                    state <= DIR;
                end else begin
                    s  <= s + 7'd1;
                    sx <= wrap ? 3'd0 : sx + 3'd1;
                    sy <= wrap ? sy + 3'd1 : sy;
                end
                DIR: if (dn[3]) begin
                    s     <= s + 7'd1;
                    sx    <= wrap ? 3'd0 : sx + 3'd1;
                    sy    <= wrap ? sy + 3'd1 : sy;
                    state <= SCAN;
                end else begin
                    // Rook and bishop take every other direction; everything else walks all eight.
                    cd    <= dn[2:0];
                    dn    <= dn + (ptype == 3'd3 || ptype == 3'd4 ? 4'd2 : 4'd1);
                    tx    <= ox;
                    ty    <= oy;
                    state <= STEP;
                end
                STEP: if (!on_brd || own) begin
                    state <= DIR;
                end else begin
                    tx   <= nx[2:0];
                    ty   <= ny[2:0];
                    cont <= t_empty && slider;
                    if (!t_empty || !caps_r) begin
                        mv_valid  <= 1'b1;
                        mv_from_x <= ox;
                        mv_from_y <= oy;
                        mv_to_x   <= nx[2:0];
                        mv_to_y   <= ny[2:0];
                        mv_cap    <= t_empty ? 3'd0 : tq[2:0];
                        state     <= EMIT;
                    end else begin
                        state <= slider ? STEP : DIR;
                    end
                end
                EMIT: if (mv_ready) begin
                    mv_valid   <= 1'b0;
                    move_count <= move_count + CNT_W'(!(&move_count));
                    state      <= cont ? STEP : DIR;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ray_move_gen.sv
// tb_ray_move_gen: directed and randomized checks of ray_move_gen on an 8x8 and a 5x5 instance
// against a ray-walking reference model.
module tb_ray_move_gen;
    logic         clk = 0, rst_n = 0, start_a = 0, start_b = 0, side = 0, caps_only = 0, mv_ready = 0, sel_b = 0;
    logic [255:0] board_a = '0;
    logic [99:0]  board_b = '0;
    logic         va, vb, busy_a, busy_b, done_a, done_b;
    logic [2:0]   fx_a, fy_a, tx_a, ty_a, cap_a, fx_b, fy_b, tx_b, ty_b, cap_b;
    logic [7:0]   cnt_a, cnt_b;
    logic         mv_v, busy_m, done_m;
    logic [14:0]  mv_m;
    logic [7:0]   cnt_m;
    int           tests = 0, fails = 0;
    logic [14:0]  got [$];
    logic [14:0]  exp [$];
    logic [15:0]  stall_obs [$];
    int kx [8] = '{1, 2, 2, 1, -1, -2, -2, -1};
    int ky [8] = '{2, 1, -1, -2, -2, -1, 1, 2};
    int rx [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int ry [8] = '{1, 1, 0, -1, -1, -1, 0, 1};

    ray_move_gen dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .side(side), .caps_only(caps_only), .board(board_a),
        .mv_valid(va), .mv_ready(mv_ready), .mv_from_x(fx_a), .mv_from_y(fy_a), .mv_to_x(tx_a),
        .mv_to_y(ty_a), .mv_cap(cap_a), .busy(busy_a), .done(done_a), .move_count(cnt_a)
    );
    ray_move_gen #(.BOARD_W(5), .BOARD_H(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .side(side), .caps_only(caps_only), .board(board_b),
        .mv_valid(vb), .mv_ready(mv_ready), .mv_from_x(fx_b), .mv_from_y(fy_b), .mv_to_x(tx_b),
        .mv_to_y(ty_b), .mv_cap(cap_b), .busy(busy_b), .done(done_b), .move_count(cnt_b)
    );

    assign mv_v   = sel_b ? vb : va;
    assign busy_m = sel_b ? busy_b : busy_a;
    assign done_m = sel_b ? done_b : done_a;
    assign cnt_m  = sel_b ? cnt_b : cnt_a;
    assign mv_m   = sel_b ? {fx_b, fy_b, tx_b, ty_b, cap_b} : {fx_a, fy_a, tx_a, ty_a, cap_a};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] mv(int fx, int fy, int tx, int ty, int cap);
        return {3'(fx), 3'(fy), 3'(tx), 3'(ty), 3'(cap)};
    endfunction

    function automatic logic [255:0] put(logic [255:0] b, int w, int x, int y, logic [3:0] p);
        b[4*(y*w+x) +: 4] = p;
        return b;
    endfunction

    // Reference: walk every ray/jump of every own piece in square, direction, distance order.
    function automatic void model(logic [255:0] b, int w, int h, logic sd, logic cp);
        logic [3:0] p, q;
        logic       e;
        int         dx, dy, cx, cy;
        exp.delete();
        for (int y = 0; y < h; y++) for (int x = 0; x < w; x++) begin
            p = b[4*(y*w+x) +: 4];
            if (p[3] != sd || p[2:0] < 2 || p[2:0] > 6) continue;
            for (int d = 0; d < 8; d++) begin
                if ((p[2:0] == 4 && d % 2 == 1) || (p[2:0] == 3 && d % 2 == 0)) continue;
                dx = p[2:0] == 2 ? kx[d] : rx[d];
                dy = p[2:0] == 2 ? ky[d] : ry[d];
                cx = x;
                cy = y;
                for (int k = 0; k < 8; k++) begin
                    cx += dx;
                    cy += dy;
                    if (cx < 0 || cx >= w || cy < 0 || cy >= h) break;
                    q = b[4*(cy*w+cx) +: 4];
                    e = q[2:0] == 0 || q[2:0] == 7;
                    if (!e && q[3] == sd) break;
                    if (!e || !cp) exp.push_back(mv(x, y, cx, cy, e ? 0 : int'(q[2:0])));
                    if (!e || p[2:0] == 2 || p[2:0] == 6) break;
                end
            end
        end
    endfunction

    // mode 0: ready always high; 1: random ready plus ignored start pokes; 2: stall the first move 5 cycles.
    task automatic run(input logic b5, input logic [255:0] brd, input logic sd, input logic cp,
                       input int mode, output int nd);
        int   tail, stall;
        logic r;
        nd = 0;
        tail = 0;
        stall = 0;
        got.delete();
        stall_obs.delete();
        @(negedge clk);
        sel_b = b5;
        board_a = brd;
        board_b = brd[99:0];
        side = sd;
        caps_only = cp;
        mv_ready = 0;
        start_a = !b5;
        start_b = b5;
        @(negedge clk);
        start_a = 0;
        start_b = 0;
        board_a = {8{$urandom}};
        board_b = 100'({4{$urandom}});
        side = 1'($urandom % 2);
        caps_only = 1'($urandom % 2);
        for (int c = 0; c < 3000 && tail < 4; c++) begin
            if (done_m) nd++;
            if (nd > 0) tail++;
            r = mode == 1 ? ($urandom % 4 != 0) : 1'b1;
            if (mode == 2 && got.size() == 0 && mv_v && stall < 5) begin
                r = 0;
                stall++;
                stall_obs.push_back({mv_v, mv_m});
            end
            start_a = mode == 1 && nd == 0 && !b5 && $urandom % 16 == 0;
            start_b = mode == 1 && nd == 0 && b5 && $urandom % 16 == 0;
            mv_ready = r;
            if (mv_v && r) got.push_back(mv_m);
            @(negedge clk);
        end
        mv_ready = 0;
        start_a = 0;
        start_b = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({va, busy_a, done_a, cnt_a} !== 11'd0) begin
            fails++;
            $display("FAIL reset_a_ctrl got v=%0b busy=%0b done=%0b cnt=%0d want all 0", va, busy_a, done_a, cnt_a);
        end
        tests++;
        if ({fx_a, fy_a, tx_a, ty_a, cap_a} !== 15'd0) begin
            fails++;
            $display("FAIL reset_a_fields got %h want 0", {fx_a, fy_a, tx_a, ty_a, cap_a});
        end
        tests++;
        if ({vb, busy_b, done_b, cnt_b, fx_b, fy_b, tx_b, ty_b, cap_b} !== 26'd0) begin
            fails++;
            $display("FAIL reset_b got v=%0b busy=%0b cnt=%0d want all 0", vb, busy_b, cnt_b);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_rook;
        int nd;
        run(0, put('0, 8, 0, 0, 4'h4), 0, 0, 0, nd);
        exp.delete();
        for (int y = 1; y < 8; y++) exp.push_back(mv(0, 0, 0, y, 0));
        for (int x = 1; x < 8; x++) exp.push_back(mv(0, 0, x, 0, 0));
        tests++;
        if (got.size() != 14) begin fails++; $display("FAIL rook_moves got %0d want 14", got.size()); end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            tests++;
            if (got[i] !== exp[i]) begin fails++; $display("FAIL rook_move[%0d] got %h want %h", i, got[i], exp[i]); end
        end
        tests++;
        if (nd != 1) begin fails++; $display("FAIL rook_done got %0d pulses want 1", nd); end
        tests++;
        if (cnt_m !== 8'd14 || busy_m !== 1'b0) begin
            fails++;
            $display("FAIL rook_count got cnt=%0d busy=%0b want 14 0", cnt_m, busy_m);
        end
    endtask

    task automatic test_knight;
        int nd;
        run(0, put(put(put('0, 8, 1, 0, 4'h2), 8, 3, 1, 4'h1), 8, 0, 2, 4'h1), 0, 0, 0, nd);
        tests++;
        if (got.size() != 1 || got[0] !== mv(1, 0, 2, 2, 0)) begin
            fails++;
            $display("FAIL knight got n=%0d first=%h want 1 %h", got.size(), got.size() ? got[0] : 15'h0, mv(1, 0, 2, 2, 0));
        end
        tests++;
        if (cnt_m !== 8'd1 || nd != 1) begin fails++; $display("FAIL knight_count got cnt=%0d done=%0d want 1 1", cnt_m, nd); end
    endtask

    task automatic test_caps_only;
        int nd;
        run(0, put(put('0, 8, 0, 0, 4'h4), 8, 0, 4, 4'hB), 0, 1, 0, nd);
        tests++;
        if (got.size() != 1 || got[0] !== mv(0, 0, 0, 4, 3)) begin
            fails++;
            $display("FAIL caps_only got n=%0d first=%h want 1 %h", got.size(), got.size() ? got[0] : 15'h0, mv(0, 0, 0, 4, 3));
        end
        tests++;
        if (cnt_m !== 8'd1 || nd != 1) begin fails++; $display("FAIL caps_count got cnt=%0d done=%0d want 1 1", cnt_m, nd); end
    endtask

    task automatic test_stall;
        int nd;
        run(0, put('0, 8, 0, 0, 4'h4), 0, 0, 2, nd);
        tests++;
        if (stall_obs.size() != 5) begin fails++; $display("FAIL stall_cycles got %0d want 5", stall_obs.size()); end
        foreach (stall_obs[i]) begin
            tests++;
            if (stall_obs[i] !== {1'b1, mv(0, 0, 0, 1, 0)}) begin
                fails++;
                $display("FAIL stall_hold[%0d] got %h want %h", i, stall_obs[i], {1'b1, mv(0, 0, 0, 1, 0)});
            end
        end
        exp.delete();
        for (int y = 1; y < 8; y++) exp.push_back(mv(0, 0, 0, y, 0));
        for (int x = 1; x < 8; x++) exp.push_back(mv(0, 0, x, 0, 0));
        tests++;
        if (got != exp || cnt_m !== 8'd14) begin
            fails++;
            $display("FAIL stall_total got n=%0d cnt=%0d want 14 14", got.size(), cnt_m);
        end
    endtask

    task automatic test_small_board;
        int   nd;
        logic bad;
        logic [255:0] b;
        b = put('0, 5, 2, 2, 4'hD);
        run(1, b, 1, 0, 0, nd);
        model(b, 5, 5, 1, 0);
        tests++;
        if (got.size() != 16) begin fails++; $display("FAIL small_moves got %0d want 16", got.size()); end
        tests++;
        if (got.size() == 0 || got[0] !== mv(2, 2, 2, 3, 0)) begin
            fails++;
            $display("FAIL small_first got %h want %h", got.size() ? got[0] : 15'h0, mv(2, 2, 2, 3, 0));
        end
        bad = 0;
        foreach (got[i]) if (got[i][14:12] > 4 || got[i][11:9] > 4 || got[i][8:6] > 4 || got[i][5:3] > 4) bad = 1;
        tests++;
        if (bad !== 1'b0) begin fails++; $display("FAIL small_coords got out-of-board coordinate want all <=4"); end
        tests++;
        if (got != exp || cnt_m !== 8'd16 || nd != 1) begin
            fails++;
            $display("FAIL small_model got n=%0d cnt=%0d done=%0d want %0d 16 1", got.size(), cnt_m, nd, exp.size());
        end
    endtask

    task automatic test_reset_mid_run;
        int nd;
        @(negedge clk);
        sel_b = 0;
        board_a = put('0, 8, 0, 0, 4'h4);
        side = 0;
        caps_only = 0;
        mv_ready = 1;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        repeat (12) @(negedge clk);
        tests++;
        if (busy_a !== 1'b1) begin fails++; $display("FAIL midrun_busy got %0b want 1", busy_a); end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        tests++;
        if ({busy_a, va, cnt_a} !== 10'd0) begin
            fails++;
            $display("FAIL midrun_reset got busy=%0b v=%0b cnt=%0d want 0 0 0", busy_a, va, cnt_a);
        end
        nd = 0;
        for (int c = 0; c < 100; c++) begin
            if (done_a) nd++;
            @(negedge clk);
        end
        mv_ready = 0;
        tests++;
        if (nd != 0) begin fails++; $display("FAIL midrun_no_done got %0d pulses want 0", nd); end
        run(0, put('0, 8, 0, 0, 4'h4), 0, 0, 0, nd);
        exp.delete();
        for (int y = 1; y < 8; y++) exp.push_back(mv(0, 0, 0, y, 0));
        for (int x = 1; x < 8; x++) exp.push_back(mv(0, 0, x, 0, 0));
        tests++;
        if (got != exp || cnt_m !== 8'd14 || nd != 1) begin
            fails++;
            $display("FAIL midrun_rerun got n=%0d cnt=%0d done=%0d want 14 14 1", got.size(), cnt_m, nd);
        end
    endtask

    task automatic test_random;
        int           nd, w, want;
        logic         b5, sd, cp;
        logic [255:0] b;
        for (int it = 0; it < 14; it++) begin
            b5 = it % 3 == 2;
            w = b5 ? 5 : 8;
            b = '0;
            for (int i = 0; i < w * w; i++) b[4*i +: 4] = ($urandom % 100 < 45) ? 4'($urandom % 16) : 4'h0;
            sd = 1'($urandom % 2);
            cp = $urandom % 3 == 0;
            model(b, w, w, sd, cp);
            run(b5, b, sd, cp, 1, nd);
            want = exp.size() > 255 ? 255 : exp.size();
            tests++;
            if (got.size() != exp.size()) begin
                fails++;
                $display("FAIL rand%0d_n got %0d want %0d", it, got.size(), exp.size());
            end
            for (int i = 0; i < got.size() && i < exp.size(); i++) begin
                tests++;
                if (got[i] !== exp[i]) begin fails++; $display("FAIL rand%0d_move[%0d] got %h want %h", it, i, got[i], exp[i]); end
            end
            tests++;
            if (nd != 1 || int'(cnt_m) != want) begin
                fails++;
                $display("FAIL rand%0d_end got done=%0d cnt=%0d want 1 %0d", it, nd, cnt_m, want);
            end
        end
    endtask

    initial begin
        test_reset;
        test_rook;
        test_knight;
        test_caps_only;
        test_stall;
        test_small_board;
        test_reset_mid_run;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
